// File: rtl/iterative_shifter.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROTL by a run-time amount, STEP bit positions per clock,
// with a Start/Busy/Done handshake and a result register that holds until the next Done.
module iterative_shifter #(
  parameter int WIDTH   = 32,
  parameter int STEP    = 1,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Start,
  input  logic [1:0]         Mode,
  input  logic [WIDTH-1:0]   In,
  input  logic [SHAMT_W-1:0] Shamt,
  output logic               Busy,
  output logic               Done,
  output logic [WIDTH-1:0]   Out
);

  localparam logic [1:0] MODE_SLL  = 2'd0;
  localparam logic [1:0] MODE_SRL  = 2'd1;
  localparam logic [1:0] MODE_SRA  = 2'd2;
  localparam logic [1:0] MODE_ROTL = 2'd3;

  // One extra bit so that STEP == WIDTH is representable in the compare
  localparam logic [SHAMT_W:0] STEP_W = (SHAMT_W+1)'(STEP);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [WIDTH-1:0]   work_r, work_nxt_s;
  logic [1:0]         mode_r, mode_nxt_s;
  logic [SHAMT_W-1:0] remain_r, remain_nxt_s;
  logic [WIDTH-1:0]   out_r, out_nxt_s;
  logic               busy_r, busy_nxt_s;
  logic               done_r, done_nxt_s;
  logic [SHAMT_W-1:0] k_s;
  logic [SHAMT_W-1:0] rot_s;
  logic [WIDTH-1:0]   shifted_s;

  // Per-clock shift amount and the shifted work value for the captured mode
  always_comb begin
    k_s       = remain_r;
    shifted_s = work_r;
    if ({1'b0, remain_r} >= STEP_W) begin
      k_s = STEP_W[SHAMT_W-1:0];
    end else begin
      k_s = remain_r;
    end
    // WIDTH - k modulo WIDTH; k == 0 degenerates to a harmless self-OR
    rot_s = {SHAMT_W{1'b0}} - k_s;
    case (mode_r)
      MODE_SLL:  shifted_s = work_r << k_s;
      MODE_SRL:  shifted_s = work_r >> k_s;
      MODE_SRA:  shifted_s = WIDTH'($signed(work_r) >>> k_s);
      MODE_ROTL: shifted_s = (work_r << k_s) | (work_r >> rot_s);
      default:   shifted_s = work_r;
    endcase
  end

  // Next-state and next-register logic
  always_comb begin
    state_nxt_s  = state_r;
    work_nxt_s   = work_r;
    mode_nxt_s   = mode_r;
    remain_nxt_s = remain_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          work_nxt_s   = In;
          mode_nxt_s   = Mode;
          remain_nxt_s = Shamt;
          state_nxt_s  = (Shamt == {SHAMT_W{1'b0}}) ? ST_DONE : ST_SHIFT;
        end else begin
          state_nxt_s  = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        work_nxt_s   = shifted_s;
        remain_nxt_s = remain_r - k_s;
        state_nxt_s  = (remain_r == k_s) ? ST_DONE : ST_SHIFT;
      end
      default: begin
        state_nxt_s  = ST_IDLE;
      end
    endcase
    // Result is latched only on the edge that enters DONE
    out_nxt_s  = (state_nxt_s == ST_DONE) ? work_nxt_s : out_r;
    busy_nxt_s = (state_nxt_s == ST_SHIFT);
    done_nxt_s = (state_nxt_s == ST_DONE);
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_r  <= ST_IDLE;
      work_r   <= {WIDTH{1'b0}};
      mode_r   <= 2'd0;
      remain_r <= {SHAMT_W{1'b0}};
      out_r    <= {WIDTH{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      work_r   <= work_nxt_s;
      mode_r   <= mode_nxt_s;
      remain_r <= remain_nxt_s;
      out_r    <= out_nxt_s;
      busy_r   <= busy_nxt_s;
      done_r   <= done_nxt_s;
    end
  end

  assign Busy = busy_r;
  assign Done = done_r;
  assign Out  = out_r;

endmodule

// File: tb/tb_iterative_shifter.sv
// Bench for iterative_shifter: directed table, hand-written handshake/reset sequences and
// random operations against a bit-level reference model, on STEP=1 and STEP=4 instances.
module tb_iterative_shifter;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        start1, start4;
  logic [1:0]  Mode;
  logic [31:0] In;
  logic [4:0]  Shamt;
  logic        busy1, done1, busy4, done4;
  logic [31:0] out1, out4;

  int vectors = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  iterative_shifter #(.WIDTH(32), .STEP(1)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(start1), .Mode(Mode), .In(In), .Shamt(Shamt),
    .Busy(busy1), .Done(done1), .Out(out1)
  );

  iterative_shifter #(.WIDTH(32), .STEP(4)) dut4 (
    .Clk(Clk), .Rst_n(Rst_n), .Start(start4), .Mode(Mode), .In(In), .Shamt(Shamt),
    .Busy(busy4), .Done(done4), .Out(out4)
  );

  typedef struct {
    bit          s4;
    logic [1:0]  m;
    logic [31:0] a;
    logic [4:0]  sh;
    logic [31:0] eo;
    int          el;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Bit-by-bit reference: each result bit is picked from its source position
  function automatic logic [31:0] ref_shift(input logic [1:0] m, input logic [31:0] a, input int sh);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      case (m)
        2'd0:    r[i] = (i >= sh) ? a[i-sh] : 1'b0;
        2'd1:    r[i] = (i + sh < 32) ? a[i+sh] : 1'b0;
        2'd2:    r[i] = (i + sh < 32) ? a[i+sh] : a[31];
        default: r[i] = a[(i - sh + 32) % 32];
      endcase
    end
    return r;
  endfunction

  task automatic do_op(input bit s4, input logic [1:0] m, input logic [31:0] a,
                       input logic [4:0] sh, input logic [31:0] eo, input int el, input string nm);
    int lat, bcnt;
    logic d, b, bad;
    logic [31:0] prev;
    @(negedge Clk);
    prev = s4 ? out4 : out1;
    Mode = m; In = a; Shamt = sh;
    if (s4) start4 = 1'b1; else start1 = 1'b1;
    @(negedge Clk);
    start1 = 1'b0; start4 = 1'b0;
    In = $urandom; Mode = 2'($urandom); Shamt = 5'($urandom);
    lat = 1; bcnt = 0; bad = 1'b0;
    forever begin
      d = s4 ? done4 : done1;
      b = s4 ? busy4 : busy1;
      if (b && d) bad = 1'b1;
      if (b) bcnt++;
      if (d || lat >= 100) break;
      if ((s4 ? out4 : out1) !== prev) bad = 1'b1;
      @(negedge Clk);
      lat++;
    end
    check({nm, " latency"}, 32'(lat), 32'(el));
    check({nm, " out"}, s4 ? out4 : out1, eo);
    check({nm, " busy cycles"}, 32'(bcnt), 32'(el - 1));
    check({nm, " excl/stable"}, {31'd0, bad}, 32'd0);
  endtask

  initial begin
    int lat, cnt;
    logic [1:0]  rm;
    logic [31:0] ra;
    logic [4:0]  rs;
    bit          r4;

    tbl[0] = '{1'b0, 2'd0, 32'h0000_0001, 5'd2,  32'h0000_0004, 3};
    tbl[1] = '{1'b0, 2'd2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 32};
    tbl[2] = '{1'b0, 2'd1, 32'h8000_0000, 5'd31, 32'h0000_0001, 32};
    tbl[3] = '{1'b0, 2'd3, 32'h8000_0001, 5'd4,  32'h0000_0018, 5};
    tbl[4] = '{1'b0, 2'd2, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1};
    tbl[5] = '{1'b0, 2'd3, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1};
    tbl[6] = '{1'b1, 2'd1, 32'hF000_0000, 5'd7,  32'h01E0_0000, 3};
    tbl[7] = '{1'b1, 2'd0, 32'h0000_0001, 5'd31, 32'h8000_0000, 9};
    tbl[8] = '{1'b1, 2'd3, 32'h8000_0001, 5'd5,  32'h0000_0030, 3};
    tbl[9] = '{1'b1, 2'd0, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1};

    Rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0; Mode = 2'd0; In = 32'd0; Shamt = 5'd0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("reset busy/done", {28'd0, busy1, done1, busy4, done4}, 32'd0);
    check("reset out1", out1, 32'd0);
    check("reset out4", out4, 32'd0);
    Rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      do_op(tbl[i].s4, tbl[i].m, tbl[i].a, tbl[i].sh, tbl[i].eo, tbl[i].el, $sformatf("tbl%0d", i));

    // Start ignored mid-shift, then a Start in the Done cycle is accepted
    @(negedge Clk);
    Mode = 2'd0; In = 32'h1; Shamt = 5'd8; start1 = 1'b1;
    @(negedge Clk);
    start1 = 1'b0; lat = 1;
    while (!done1 && lat < 100) begin
      if (lat == 3) begin start1 = 1'b1; In = 32'hFFFF_FFFF; Shamt = 5'd3; end
      else start1 = 1'b0;
      @(negedge Clk);
      lat++;
    end
    check("midstart latency", 32'(lat), 32'd9);
    check("midstart out", out1, 32'h0000_0100);
    Mode = 2'd0; In = 32'h2; Shamt = 5'd1; start1 = 1'b1;
    @(negedge Clk);
    start1 = 1'b0; lat = 1;
    while (!done1 && lat < 100) begin
      @(negedge Clk);
      lat++;
    end
    check("b2b latency", 32'(lat), 32'd2);
    check("b2b out", out1, 32'h0000_0004);
    cnt = 0;
    repeat (40) begin @(negedge Clk); if (done1) cnt++; end
    check("no queued done", 32'(cnt), 32'd0);

    // Reset in the middle of a shift aborts it
    Mode = 2'd0; In = 32'h1; Shamt = 5'd20; start1 = 1'b1;
    @(negedge Clk);
    start1 = 1'b0;
    repeat (3) @(negedge Clk);
    Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    check("abort busy/done", {30'd0, busy1, done1}, 32'd0);
    check("abort out", out1, 32'd0);
    cnt = 0;
    repeat (40) begin @(negedge Clk); if (done1 || busy1) cnt++; end
    check("abort no done", 32'(cnt), 32'd0);

    for (int i = 0; i < 150; i++) begin
      r4 = 1'($urandom);
      rm = 2'($urandom);
      ra = $urandom;
      rs = 5'($urandom);
      do_op(r4, rm, ra, rs, ref_shift(rm, ra, int'(rs)),
            r4 ? (int'(rs) + 3) / 4 + 1 : int'(rs) + 1, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
